multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore-style FSM controller for the multi-cycle MIPS datapath. Replaces the single-cycle decoder path.
- Sequences fetch, decode, execute, memory and writeback over several cycles on a shared instruction/data memory and a single ALU.
- Stalls memory-access states until the unified memory handshakes `mem_ready`.
- Supports R-type (add/sub/and/or/slt), lw, sw, beq, addi and j.

Parameters:
- STATE_W, 4, width of state register and debug state port

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- op  input  6  instruction[31:26] from instruction register
- funct  input  6  instruction[5:0] from instruction register
- zero  input  1  ALU zero flag, same cycle
- mem_ready  input  1  unified memory completes current access this cycle
- iord  output  1  memory address select: 0=PC, 1=ALUOut
- irwrite  output  1  instruction register load enable
- memwrite  output  1  memory write strobe
- pcen  output  1  PC load enable = pcwrite | (branch & zero)
- regwrite  output  1  register file write enable
- regdst  output  1  write register select: 0=rt, 1=rd
- memtoreg  output  1  writeback select: 0=ALUOut, 1=memory data register
- alusrca  output  1  ALU A select: 0=PC, 1=regA
- alusrcb  output  2  ALU B select: 00=regB, 01=const 4, 10=signimm, 11=signimm<<2
- pcsrc  output  2  next-PC select: 00=ALU result, 01=ALUOut, 10=jump target
- alucontrol  output  3  ALU operation (010 add, 110 sub, 000 and, 001 or, 111 slt)
- instr_done  output  1  one-cycle pulse in final cycle of each instruction
- illegal_op  output  1  one-cycle pulse in DECODE on unsupported opcode
- state  output  STATE_W  current state, for debug and bench

Behaviour:
- Reset:
  - `rst` high at a clock edge sets state to FETCH.
  - While `rst` is high, all outputs are forced to 0 combinationally, so no PC, IR, memory or register writes occur during reset.
  - `rst` asserted in any state aborts the instruction; state is FETCH on the next cycle.
- Output classes:
  - Outputs are decoded from state only, except `irwrite`, `pcen`, `instr_done` and `illegal_op`, which also qualify on `mem_ready`, `zero` or `op`.
  - Outputs not listed for a state are 0.
- FETCH: `alusrca`=0, `alusrcb`=01, aluop=add, `pcsrc`=00, `iord`=0.
  - `irwrite` and pcwrite equal `mem_ready`.
  - Stay in FETCH while `mem_ready`=0; go to DECODE when `mem_ready`=1.
- DECODE: `alusrca`=0, `alusrcb`=11, aluop=add (branch target into ALUOut). Next state by opcode:
  - lw/sw (100011/101011) -> MEMADR
  - R-type (000000) -> EXECUTE
  - beq (000100) -> BRANCH
  - addi (001000) -> ADDIEXEC
  - j (000010) -> JUMP
  - any other opcode -> FETCH, with `illegal_op`=1 for this cycle
- MEMADR: `alusrca`=1, `alusrcb`=10, aluop=add. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: `iord`=1. Hold until `mem_ready`=1, then go to MEMWB.
- MEMWB: `regwrite`=1, `regdst`=0, `memtoreg`=1, `instr_done`=1. Next is FETCH.
- MEMWR: `iord`=1, `memwrite`=1, held every cycle until `mem_ready`=1. `instr_done`=`mem_ready`. Next is FETCH on `mem_ready`=1.
- EXECUTE: `alusrca`=1, `alusrcb`=00, aluop=funct. Next is ALUWB.
- ALUWB: `regwrite`=1, `regdst`=1, `memtoreg`=0, `instr_done`=1. Next is FETCH.
- BRANCH: `alusrca`=1, `alusrcb`=00, aluop=sub, `pcsrc`=01, branch=1, `instr_done`=1. Next is FETCH.
- ADDIEXEC: `alusrca`=1, `alusrcb`=10, aluop=add. Next is ADDIWB.
- ADDIWB: `regwrite`=1, `regdst`=0, `memtoreg`=0, `instr_done`=1. Next is FETCH.
- JUMP: `pcsrc`=10, pcwrite=1, `instr_done`=1. Next is FETCH.
- ALU decode:
  - aluop 00 gives add, 01 gives sub.
  - aluop 10 decodes funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Unknown funct gives `alucontrol`=000; no trap.
- Latency with `mem_ready` tied to 1:
  - lw 5 cycles
  - sw, R-type, addi 4 cycles
  - beq, j 3 cycles
  - Each wait cycle adds one cycle.
- Simultaneous events:
  - `op`/`funct` are sampled only in DECODE/EXECUTE.
  - `zero` is sampled only in BRANCH.
  - `mem_ready` is ignored outside FETCH, MEMRD and MEMWR.

Decomposition:
- Shared package `mips_defs`:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - funct constants
  - aluop encodings
  - alucontrol encodings
  - state encoding localparams (12 states, 4 bits)
- One sub-module: reuse the existing `alu_decoder` (funct, aluop -> alucontrol) unchanged.
- FSM next-state and output decode stay in `multicycle_controller`.

Test Plan:
- Reset: `rst`=1 for 2 cycles, then release with `mem_ready`=1 -> all outputs 0 during reset; `state`=FETCH after release; `irwrite`=1 and `pcen`=1 in the first FETCH cycle.
- lw (`op`=100011), `mem_ready`=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; `regwrite`=1, `memtoreg`=1, `regdst`=0 in cycle 5; `instr_done` pulses once.
- sw with `mem_ready` low 3 cycles in MEMWR -> `memwrite`=1 for 4 consecutive cycles; `instr_done` only in the final cycle; 7 cycles total.
- beq, `zero`=1 then repeated with `zero`=0 -> `pcen`=1 with `pcsrc`=01 in BRANCH for the first run; `pcen`=0 for the second.
- R-type `funct`=101010 -> `alucontrol`=111 in EXECUTE; `regdst`=1, `regwrite`=1 in ALUWB. j -> `pcsrc`=10, `pcen`=1 in cycle 3.
- `op`=111111 -> `illegal_op`=1 in DECODE, return to FETCH, no write strobes. Also: `rst` asserted mid-MEMRD -> FETCH next cycle, `regwrite` never asserted.

Source files
------------

// File: rtl/mips_defs.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, functs,
// ALU operation codes and the controller state encoding.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMRD    = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWR    = 4'd5;
    localparam logic [3:0] S_EXECUTE  = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_ADDIEXEC = 4'd9;
    localparam logic [3:0] S_ADDIWB   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU control decode: fixed add/sub from the FSM, or funct-driven for R-type.
module alu_decoder
    import mips_defs::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        // NOTE: assign a default first in every combinational block so no path can infer a latch.
        alucontrol = ALU_AND;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucontrol = ALU_ADD;
                    FUNCT_SUB: alucontrol = ALU_SUB;
                    FUNCT_AND: alucontrol = ALU_AND;
                    FUNCT_OR:  alucontrol = ALU_OR;
                    FUNCT_SLT: alucontrol = ALU_SLT;
                    default:   alucontrol = ALU_AND;
                endcase
            end
            default: alucontrol = ALU_AND;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing fetch/decode/execute/memory/writeback for the
// multi-cycle MIPS datapath on a unified memory with a ready handshake.
module multicycle_controller
    import mips_defs::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               iord,
    output logic               irwrite,
    output logic               memwrite,
    output logic               pcen,
    output logic               regwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic [2:0]         alucontrol,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    logic [STATE_W-1:0] state_q, state_d;
    logic               is_store_q;
    logic [1:0]         aluop;
    logic [2:0]         alu_dec;
    logic               alu_used, pcwrite, branch;

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alu_dec)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q    <= S_FETCH;
            is_store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // Remember lw vs sw so op is looked at only while decoding.
            if (state_q == S_DECODE) is_store_q <= (op == OP_SW);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = is_store_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:    if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:    if (mem_ready) state_d = S_FETCH;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        iord       = 1'b0;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        aluop      = ALUOP_ADD;
        alu_used   = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb  = 2'b01;
                alu_used = 1'b1;
                irwrite  = mem_ready;
                pcwrite  = mem_ready;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                alu_used   = 1'b1;
                illegal_op = !op_supported(op);
            end
            S_MEMADR, S_ADDIEXEC: begin
                alusrca  = 1'b1;
                alusrcb  = 2'b10;
                alu_used = 1'b1;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite   = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECUTE: begin
                alusrca  = 1'b1;
                aluop    = ALUOP_FUNCT;
                alu_used = 1'b1;
            end
            S_ALUWB: begin
                regwrite   = 1'b1;
                regdst     = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_SUB;
                alu_used   = 1'b1;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pcsrc      = 2'b10;
                pcwrite    = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase

        alucontrol = alu_used ? alu_dec : 3'b000;
        pcen       = pcwrite | (branch & zero);
        state      = state_q;

        // Reset blanks every strobe so nothing is written while held in reset.
        if (rst) begin
            iord       = 1'b0;
            irwrite    = 1'b0;
            memwrite   = 1'b0;
            pcen       = 1'b0;
            regwrite   = 1'b0;
            regdst     = 1'b0;
            memtoreg   = 1'b0;
            alusrca    = 1'b0;
            alusrcb    = 2'b00;
            pcsrc      = 2'b00;
            alucontrol = 3'b000;
            instr_done = 1'b0;
            illegal_op = 1'b0;
            state      = '0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed per-cycle bench: expected control vectors queued with each stimulus
// step and compared against the DUT on the falling edge.
module tb_multicycle_controller;
    import mips_defs::*;

    typedef struct packed {
        logic [3:0] st;
        logic       iord, irwrite, memwrite, pcen, regwrite, regdst, memtoreg, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic [2:0] alucontrol;
        logic       instr_done, illegal_op;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst, zero, mem_ready;
    logic [5:0] op, funct;
    logic       iord, irwrite, memwrite, pcen, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    obs_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .pcen(pcen),
        .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
    );

    function automatic obs_t o(input logic [3:0] st, input logic io, input logic irw,
                               input logic mw, input logic pce, input logic rw,
                               input logic rd, input logic m2r, input logic asa,
                               input logic [1:0] asb, input logic [1:0] pcs,
                               input logic [2:0] alc, input logic done, input logic ill);
        obs_t r;
        r = '{st, io, irw, mw, pce, rw, rd, m2r, asa, asb, pcs, alc, done, ill};
        return r;
    endfunction

    // Drive one cycle of inputs, queue its expectation, compare mid-cycle.
    task automatic cyc(input string tag, input logic r, input logic mr, input logic z,
                       input obs_t e);
        obs_t act, want;
        rst = r; mem_ready = mr; zero = z;
        exp_q.push_back(e);
        @(negedge clk);
        act  = '{state, iord, irwrite, memwrite, pcen, regwrite, regdst, memtoreg,
                 alusrca, alusrcb, pcsrc, alucontrol, instr_done, illegal_op};
        want = exp_q.pop_front();
        total++;
        assert (act === want) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, act, want);
        @(posedge clk);
        #1;
    endtask

    obs_t idle0, fetch_go, fetch_wait, decode;

    initial begin
        idle0      = o(S_FETCH, 0,0,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0,0);
        fetch_go   = o(S_FETCH, 0,1,0,1,0,0,0,0, 2'b01, 2'b00, 3'b010, 0,0);
        fetch_wait = o(S_FETCH, 0,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 0,0);
        decode     = o(S_DECODE,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 0,0);
        op = OP_LW; funct = 6'b0;

        cyc("rst_c1", 1, 1, 0, idle0);
        cyc("rst_c2", 1, 1, 0, idle0);

        // lw, memory always ready: 5 cycles
        cyc("lw_fetch",  0, 1, 0, fetch_go);
        cyc("lw_decode", 0, 1, 0, decode);
        cyc("lw_memadr", 0, 1, 0, o(S_MEMADR,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0,0));
        cyc("lw_memrd",  0, 1, 0, o(S_MEMRD, 1,0,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0,0));
        cyc("lw_memwb",  0, 1, 0, o(S_MEMWB, 0,0,0,0,1,0,1,0, 2'b00, 2'b00, 3'b000, 1,0));

        // fetch stall, then sw with 3 wait cycles in MEMWR: 7 cycles after the stall
        op = OP_SW;
        cyc("sw_fetch_wait", 0, 0, 0, fetch_wait);
        cyc("sw_fetch",      0, 1, 0, fetch_go);
        cyc("sw_decode",     0, 1, 0, decode);
        cyc("sw_memadr",     0, 0, 0, o(S_MEMADR,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0,0));
        for (int i = 0; i < 3; i++)
            cyc("sw_memwr_wait", 0, 0, 0, o(S_MEMWR,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0,0));
        cyc("sw_memwr_done", 0, 1, 0, o(S_MEMWR,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 1,0));

        // beq taken, then not taken
        op = OP_BEQ;
        cyc("beq1_fetch",  0, 1, 0, fetch_go);
        cyc("beq1_decode", 0, 1, 1, decode);
        cyc("beq1_branch", 0, 1, 1, o(S_BRANCH,0,0,0,1,0,0,0,1, 2'b00, 2'b01, 3'b110, 1,0));
        cyc("beq0_fetch",  0, 1, 1, fetch_go);
        cyc("beq0_decode", 0, 1, 0, decode);
        cyc("beq0_branch", 0, 1, 0, o(S_BRANCH,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 3'b110, 1,0));

        // R-type slt, sub, and an unknown funct
        op = OP_RTYPE; funct = FUNCT_SLT;
        cyc("slt_fetch",  0, 1, 0, fetch_go);
        cyc("slt_decode", 0, 1, 0, decode);
        cyc("slt_exec",   0, 0, 0, o(S_EXECUTE,0,0,0,0,0,0,0,1, 2'b00, 2'b00, 3'b111, 0,0));
        cyc("slt_aluwb",  0, 1, 0, o(S_ALUWB, 0,0,0,0,1,1,0,0, 2'b00, 2'b00, 3'b000, 1,0));
        funct = FUNCT_SUB;
        cyc("sub_fetch",  0, 1, 0, fetch_go);
        cyc("sub_decode", 0, 1, 0, decode);
        cyc("sub_exec",   0, 1, 0, o(S_EXECUTE,0,0,0,0,0,0,0,1, 2'b00, 2'b00, 3'b110, 0,0));
        cyc("sub_aluwb",  0, 1, 0, o(S_ALUWB, 0,0,0,0,1,1,0,0, 2'b00, 2'b00, 3'b000, 1,0));
        funct = 6'b111111;
        cyc("unk_fetch",  0, 1, 0, fetch_go);
        cyc("unk_decode", 0, 1, 0, decode);
        cyc("unk_exec",   0, 1, 0, o(S_EXECUTE,0,0,0,0,0,0,0,1, 2'b00, 2'b00, 3'b000, 0,0));
        cyc("unk_aluwb",  0, 1, 0, o(S_ALUWB, 0,0,0,0,1,1,0,0, 2'b00, 2'b00, 3'b000, 1,0));

        // addi
        op = OP_ADDI; funct = 6'b0;
        cyc("addi_fetch",  0, 1, 0, fetch_go);
        cyc("addi_decode", 0, 1, 0, decode);
        cyc("addi_exec",   0, 1, 0, o(S_ADDIEXEC,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0,0));
        cyc("addi_wb",     0, 1, 0, o(S_ADDIWB, 0,0,0,0,1,0,0,0, 2'b00, 2'b00, 3'b000, 1,0));

        // j
        op = OP_J;
        cyc("j_fetch",  0, 1, 0, fetch_go);
        cyc("j_decode", 0, 1, 0, decode);
        cyc("j_jump",   0, 0, 0, o(S_JUMP,0,0,0,1,0,0,0,0, 2'b00, 2'b10, 3'b000, 1,0));

        // unsupported opcode
        op = 6'b111111;
        cyc("ill_fetch",  0, 1, 0, fetch_go);
        cyc("ill_decode", 0, 1, 0, o(S_DECODE,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 0,1));
        cyc("ill_return", 0, 0, 0, fetch_wait);

        // reset while stalled in MEMRD aborts the load
        op = OP_LW;
        cyc("ab_fetch",  0, 1, 0, fetch_go);
        cyc("ab_decode", 0, 1, 0, decode);
        cyc("ab_memadr", 0, 1, 0, o(S_MEMADR,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0,0));
        cyc("ab_memrd",  0, 0, 0, o(S_MEMRD, 1,0,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0,0));
        cyc("ab_rst",    1, 1, 0, idle0);
        cyc("ab_fetch2", 0, 1, 0, fetch_go);
        cyc("ab_decode2",0, 1, 0, decode);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
